// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RESP_I = 2'd1,
        ST_RESP_D = 2'd2
    } arb_state_e;

    localparam logic [2:0] FUNCT3_LW      = 3'b010;
    localparam int         DEFAULT_ADDR_W = 6;

endpackage

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and data access.
// Data wins by default; a bounded starvation counter guarantees fetch progress.
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   ST_IDLE   | no response due this cycle
//   ST_RESP_I | fetch data registered last edge, if_rvalid high
//   ST_RESP_D | load data / store ack due, dm_rvalid high
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = DEFAULT_ADDR_W,
    parameter int STARVE_MAX = 3
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_gnt,
    output logic              if_rvalid,
    output logic [31:0]       if_rdata,

    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [2:0]        dm_funct3,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [31:0]       dm_wdata,
    output logic              dm_gnt,
    output logic              dm_rvalid,
    output logic [31:0]       dm_rdata,

    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_re,
    output logic              mem_we,
    output logic [2:0]        mem_funct3,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,

    output logic              pc_stall
);

    localparam int              CNT_W      = (STARVE_MAX < 2) ? 1 : $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] STARVE_TOP = CNT_W'(STARVE_MAX);

    arb_state_e       state_q, state_d;
    logic [CNT_W-1:0] starve_q, starve_d;
    logic [31:0]      if_rdata_q, if_rdata_d;
    logic [31:0]      dm_rdata_q, dm_rdata_d;
    logic             force_if;

    // Fetch takes the port only when data is idle or fetch has waited too long.
    assign force_if = if_req && (starve_q == STARVE_TOP);
    assign dm_gnt   = rst_n & dm_req & ~force_if;
    assign if_gnt   = rst_n & if_req & ~dm_gnt;
    assign pc_stall = if_req & ~if_gnt;

    always_comb begin
        starve_d   = starve_q;
        state_d    = ST_IDLE;
        if_rdata_d = if_rdata_q;
        dm_rdata_d = dm_rdata_q;
        mem_addr   = '0;
        mem_re     = 1'b0;
        mem_we     = 1'b0;
        mem_funct3 = 3'b000;
        mem_wdata  = '0;

        if (!if_req || if_gnt) begin
            starve_d = '0;
        end else if (dm_gnt && (starve_q != STARVE_TOP)) begin
            starve_d = starve_q + CNT_W'(1);
        end

        if (dm_gnt) begin
            state_d    = ST_RESP_D;
            mem_addr   = dm_addr;
            mem_funct3 = dm_funct3;
            mem_wdata  = dm_wdata;
            mem_we     = dm_we;
            mem_re     = ~dm_we;
            // Stores return a zero word alongside the acknowledge.
            dm_rdata_d = dm_we ? 32'd0 : mem_rdata;
        end else if (if_gnt) begin
            state_d    = ST_RESP_I;
            mem_addr   = if_addr;
            mem_funct3 = FUNCT3_LW;
            mem_re     = 1'b1;
            if_rdata_d = mem_rdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            starve_q   <= '0;
            if_rdata_q <= '0;
            dm_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            starve_q   <= starve_d;
            if_rdata_q <= if_rdata_d;
            dm_rdata_q <= dm_rdata_d;
        end
    end

    assign if_rvalid = (state_q == ST_RESP_I);
    assign dm_rvalid = (state_q == ST_RESP_D);
    assign if_rdata  = if_rdata_q;
    assign dm_rdata  = dm_rdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a combinational-read memory model.
module tb_mem_port_arbiter;

    localparam int ADDR_W = 6;

    logic              clk;
    logic              rst_n;
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_gnt;
    logic              if_rvalid;
    logic [31:0]       if_rdata;
    logic              dm_req;
    logic              dm_we;
    logic [2:0]        dm_funct3;
    logic [ADDR_W-1:0] dm_addr;
    logic [31:0]       dm_wdata;
    logic              dm_gnt;
    logic              dm_rvalid;
    logic [31:0]       dm_rdata;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_re;
    logic              mem_we;
    logic [2:0]        mem_funct3;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              pc_stall;

    logic [31:0] mem [64];
    int n_tests = 0;
    int n_fail  = 0;

    mem_port_arbiter #(.ADDR_W(ADDR_W), .STARVE_MAX(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_funct3(dm_funct3),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_gnt(dm_gnt),
        .dm_rvalid(dm_rvalid), .dm_rdata(dm_rdata),
        .mem_addr(mem_addr), .mem_re(mem_re), .mem_we(mem_we),
        .mem_funct3(mem_funct3), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .pc_stall(pc_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];
    always @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Move to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        if_req    = 1'b0;
        if_addr   = '0;
        dm_req    = 1'b0;
        dm_we     = 1'b0;
        dm_funct3 = 3'b010;
        dm_addr   = '0;
        dm_wdata  = '0;
    endtask

    logic [1:0] exp_seq [5];
    logic [1:0] gnt_code;

    initial begin
        for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + i;
        mem[5] = 32'h00A0_0093;
        mem[2] = 32'hFFFF_FF9C;
        idle_inputs();
        rst_n = 1'b0;

        // Reset: registered outputs cleared, grants suppressed despite requests.
        if_req = 1'b1;
        dm_req = 1'b1;
        #12;
        check("rst_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("rst_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        check("rst_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        check("rst_dm_rvalid", {31'd0, dm_rvalid}, 32'd0);
        check("rst_if_rdata", if_rdata, 32'd0);
        check("rst_dm_rdata", dm_rdata, 32'd0);
        idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;

        // Idle: all memory outputs quiet.
        tick();
        #1;
        check("idle_mem_bus", {mem_addr, mem_re, mem_we, mem_funct3, mem_wdata == 32'd0}, {6'd0, 1'b0, 1'b0, 3'd0, 1'b1});
        check("idle_pc_stall", {31'd0, pc_stall}, 32'd0);

        // Fetch only.
        if_req  = 1'b1;
        if_addr = 6'd5;
        #1;
        check("fetch_if_gnt", {31'd0, if_gnt}, 32'd1);
        check("fetch_dm_gnt", {31'd0, dm_gnt}, 32'd0);
        check("fetch_pc_stall", {31'd0, pc_stall}, 32'd0);
        check("fetch_mem_ctl", {mem_re, mem_we, mem_funct3}, {27'd0, 1'b1, 1'b0, 3'b010});
        check("fetch_mem_addr", {26'd0, mem_addr}, 32'd5);
        check("fetch_mem_wdata", mem_wdata, 32'd0);
        tick();
        check("fetch_if_rvalid", {31'd0, if_rvalid}, 32'd1);
        check("fetch_if_rdata", if_rdata, 32'h00A0_0093);
        idle_inputs();
        tick();
        check("fetch_rvalid_drop", {31'd0, if_rvalid}, 32'd0);
        check("fetch_rdata_hold", if_rdata, 32'h00A0_0093);

        // Collision: data wins, fetch stalls.
        if_req  = 1'b1;
        if_addr = 6'd5;
        dm_req  = 1'b1;
        dm_addr = 6'd2;
        #1;
        check("coll_dm_gnt", {31'd0, dm_gnt}, 32'd1);
        check("coll_if_gnt", {31'd0, if_gnt}, 32'd0);
        check("coll_pc_stall", {31'd0, pc_stall}, 32'd1);
        check("coll_mem_addr", {26'd0, mem_addr}, 32'd2);
        tick();
        idle_inputs();
        #1;
        check("coll_dm_rvalid", {31'd0, dm_rvalid}, 32'd1);
        check("coll_dm_rdata", dm_rdata, 32'hFFFF_FF9C);
        check("coll_if_rvalid", {31'd0, if_rvalid}, 32'd0);
        tick();

        // Starvation: D,D,D,I,D with both requests held.
        exp_seq[0] = 2'b01; exp_seq[1] = 2'b01; exp_seq[2] = 2'b01;
        exp_seq[3] = 2'b10; exp_seq[4] = 2'b01;
        if_req  = 1'b1;
        if_addr = 6'd5;
        dm_req  = 1'b1;
        dm_addr = 6'd2;
        for (int c = 0; c < 5; c++) begin
            #1;
            gnt_code = {if_gnt, dm_gnt};
            check($sformatf("starve_gnt%0d", c), {30'd0, gnt_code}, {30'd0, exp_seq[c]});
            tick();
            if (c == 3) begin
                check("starve_if_rvalid", {31'd0, if_rvalid}, 32'd1);
                check("starve_if_rdata", if_rdata, 32'h00A0_0093);
            end
        end
        idle_inputs();
        tick();

        // Store: one write pulse, ack with zero data, memory updated.
        dm_req   = 1'b1;
        dm_we    = 1'b1;
        dm_addr  = 6'd4;
        dm_wdata = 32'd6;
        #1;
        check("store_mem_ctl", {29'd0, mem_we, mem_re, dm_gnt}, {29'd0, 3'b101});
        check("store_mem_wdata", mem_wdata, 32'd6);
        check("store_mem_addr", {26'd0, mem_addr}, 32'd4);
        tick();
        idle_inputs();
        #1;
        check("store_ack", {31'd0, dm_rvalid}, 32'd1);
        check("store_rdata", dm_rdata, 32'd0);
        check("store_we_drop", {31'd0, mem_we}, 32'd0);
        check("store_mem4", mem[4], 32'd6);

        // Reset mid-response: pending data response is dropped.
        tick();
        dm_req  = 1'b1;
        dm_addr = 6'd2;
        tick();
        idle_inputs();
        check("rmid_rvalid_pre", {31'd0, dm_rvalid}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rmid_rvalid_drop", {31'd0, dm_rvalid}, 32'd0);
        check("rmid_rdata_clr", dm_rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            check($sformatf("rmid_no_rvalid%0d", c), {30'd0, if_rvalid, dm_rvalid}, 32'd0);
        end

        // First grant right after a fresh release.
        rst_n = 1'b0;
        #2;
        if_req  = 1'b1;
        if_addr = 6'd5;
        #1;
        check("rel_gnt_in_rst", {31'd0, if_gnt}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("rel_first_gnt", {31'd0, if_gnt}, 32'd1);
        tick();
        check("rel_first_rdata", if_rdata, 32'h00A0_0093);
        idle_inputs();
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
